// File: rtl/input_debounce4.sv
// Four-channel synchroniser and debouncer feeding the a/b/c/d logic inputs.
// Each channel flips only after DB_CYCLES consecutive differing samples; flips are reported by a one-cycle strobe.
module input_debounce4 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw_in,
  input  logic       en,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       chg,
  output logic [3:0] chg_mask
);

  localparam int unsigned NCH = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   sync_d [SYNC_STAGES];
  state_t           state_q [NCH];
  state_t           state_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   out_q, out_d;
  logic [NCH-1:0]   flip_q, flip_d;
  logic [NCH-1:0]   chg_mask_q, chg_mask_d;
  logic             chg_q, chg_d;
  logic [NCH-1:0]   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; runs regardless of en
  always_comb begin
    sync_d[0] = raw_in;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Per-channel STABLE/PENDING debounce FSM
  always_comb begin
    out_d  = out_q;
    flip_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (en) begin
        case (state_q[i])
          ST_STABLE: begin
            if (s[i] != out_q[i]) begin
              cnt_d[i]   = CNT_W'(1);
              state_d[i] = ST_PENDING;
            end
          end
          ST_PENDING: begin
            if (s[i] == out_q[i]) begin
              cnt_d[i]   = '0;
              state_d[i] = ST_STABLE;
            end else if (cnt_q[i] == CNT_LAST) begin
              out_d[i]   = s[i];
              cnt_d[i]   = '0;
              state_d[i] = ST_STABLE;
              flip_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            cnt_d[i]   = '0;
            state_d[i] = ST_STABLE;
          end
        endcase
      end
    end
  end

  // Strobe trails the flip by one edge
  always_comb begin
    chg_d      = |flip_q;
    chg_mask_d = flip_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      out_q      <= '0;
      flip_q     <= '0;
      chg_q      <= 1'b0;
      chg_mask_q <= '0;
    end else begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      out_q      <= out_d;
      flip_q     <= flip_d;
      chg_q      <= chg_d;
      chg_mask_q <= chg_mask_d;
    end
  end

  assign a        = out_q[0];
  assign b        = out_q[1];
  assign c        = out_q[2];
  assign d        = out_q[3];
  assign chg      = chg_q;
  assign chg_mask = chg_mask_q;

endmodule

// File: tb/tb_input_debounce4.sv
// Bench for input_debounce4 (DB_CYCLES=4, SYNC_STAGES=2): directed stimulus with
// a queue of expected change strobes checked by an independent monitor.
module tb_input_debounce4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_in;
  logic       en;
  logic       a, b, c, d;
  logic       chg;
  logic [3:0] chg_mask;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];   // {mask, levels {d,c,b,a}} expected with each chg pulse

  input_debounce4 #(
    .SYNC_STAGES(2),
    .DB_CYCLES  (4),
    .CNT_W      (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_in  (raw_in),
    .en      (en),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .chg     (chg),
    .chg_mask(chg_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] lv();
    return {d, c, b, a};
  endfunction

  // Monitor: every chg pulse must match the head of the expectation queue
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1) begin
        if (chg === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_chg: got mask %0h expected no pulse at %0t", chg_mask, $time);
          end else begin
            e = exp_q.pop_front();
            chk("chg_mask", 32'(chg_mask), 32'(e[7:4]));
            chk("chg_levels", 32'(lv()), 32'(e[3:0]));
          end
        end else begin
          chk("chg_mask_idle", 32'(chg_mask), 32'h0);
        end
      end
    end
  end

  initial begin
    logic [8:0] bounce;
    rst_n  = 1'b0;
    en     = 1'b1;
    raw_in = 4'hF;

    // 1 Reset, then all-ones qualifies at edge 6 with strobe at edge 7
    tick(2);
    chk("reset_levels", 32'(lv()), 32'h0);
    chk("reset_chg", 32'(chg), 32'h0);
    rst_n = 1'b1;
    exp_q.push_back({4'hF, 4'hF});
    tick(5);
    chk("rise_before_latency", 32'(lv()), 32'h0);
    tick(1);
    chk("rise_at_edge6", 32'(lv()), 32'hF);
    tick(1);
    raw_in = 4'h0;
    exp_q.push_back({4'hF, 4'h0});
    tick(5);
    chk("fall_before_latency", 32'(lv()), 32'hF);
    tick(1);
    chk("fall_at_edge6", 32'(lv()), 32'h0);
    tick(2);

    // 2 Glitch of 3 cycles is rejected; 4-cycle pulse gives a 4-cycle output
    raw_in = 4'h1;
    tick(3);
    raw_in = 4'h0;
    tick(4);
    chk("glitch_a_mid", 32'(a), 32'h0);
    tick(6);
    chk("glitch_a_end", 32'(a), 32'h0);
    exp_q.push_back({4'h1, 4'h1});
    exp_q.push_back({4'h1, 4'h0});
    raw_in = 4'h1;
    tick(4);
    raw_in = 4'h0;
    tick(1);
    chk("pulse4_a_edge5", 32'(a), 32'h0);
    tick(1);
    chk("pulse4_a_edge6", 32'(a), 32'h1);
    tick(3);
    chk("pulse4_a_edge9", 32'(a), 32'h1);
    tick(1);
    chk("pulse4_a_edge10", 32'(a), 32'h0);
    tick(3);

    // 3 Enable low freezes channel 1; flip on 4th edge after en rises
    en     = 1'b0;
    raw_in = 4'h2;
    tick(10);
    chk("en_low_b", 32'(b), 32'h0);
    en = 1'b1;
    exp_q.push_back({4'h2, 4'h2});
    tick(3);
    chk("en_edge3_b", 32'(b), 32'h0);
    tick(1);
    chk("en_edge4_b", 32'(b), 32'h1);
    tick(2);
    raw_in = 4'h0;
    exp_q.push_back({4'h2, 4'h0});
    tick(8);

    // 4 Simultaneous rise of a and c shares one strobe
    raw_in = 4'h5;
    exp_q.push_back({4'h5, 4'h5});
    tick(5);
    chk("simul_edge5", 32'(lv()), 32'h0);
    tick(1);
    chk("simul_edge6", 32'(lv()), 32'h5);
    tick(2);
    raw_in = 4'h0;
    exp_q.push_back({4'h5, 4'h0});
    tick(8);

    // 5 Reset while channel 3 is pending; full latency after release
    raw_in = 4'h8;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_d", 32'(d), 32'h0);
    chk("rst_mid_chg", 32'(chg), 32'h0);
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back({4'h8, 4'h8});
    tick(5);
    chk("rst_rel_edge5_d", 32'(d), 32'h0);
    tick(1);
    chk("rst_rel_edge6_d", 32'(d), 32'h1);
    tick(2);
    raw_in = 4'h0;
    exp_q.push_back({4'h8, 4'h0});
    tick(8);

    // 6 Bouncing channel 2 flips once, at the end of the 4-long run
    bounce = 9'b111101101;   // bit k is the raw level for cycle k
    exp_q.push_back({4'h4, 4'h4});
    for (int k = 0; k < 9; k++) begin
      raw_in = {1'b0, bounce[k], 2'b00};
      tick(1);
      if (k == 4) chk("bounce_c_mid", 32'(c), 32'h0);
    end
    tick(1);
    chk("bounce_c_edge10", 32'(c), 32'h0);
    tick(1);
    chk("bounce_c_edge11", 32'(c), 32'h1);
    tick(4);

    chk("pending_strobes", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
